// File: rtl/usrt_pkg.sv
// Shared constants and state encoding for the USRT transmitter.
package usrt_pkg;

    // Payload bits per frame and the width needed to index them.
    localparam int DATA_W    = 8;
    localparam int BIT_IDX_W = $clog2(DATA_W);

    // One bit time per state, except DATA, which lasts DATA_W bit times.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        STRT  = 3'd2,
        DATA  = 3'd3,
        PAR   = 3'd4,
        STOP  = 3'd5
    } state_e;

endpackage

// File: rtl/usrt_if.sv
// Serial line bundle: bit clock, enables and the driven line (RTS/TXD).
interface usrt_if;

    logic usrt_clk;
    logic start;
    logic sw6;
    logic RTS;
    logic TXD;

    // The line driver (the controlling board logic) drives the enables and bit clock.
    modport master (output usrt_clk, output start, output sw6, input RTS, input TXD);
    // The transmitter consumes the enables and bit clock, and drives the line.
    modport slave  (input usrt_clk, input start, input sw6, output RTS, output TXD);

endinterface

// File: rtl/usrt_edge_sync.sv
// Synchroniser for one asynchronous input: gives the synced level and a
// one-cycle pulse on each synced falling edge.
module usrt_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;

    // Shift the async input through the flop chain and remember last synced level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value; blocking would collapse the chain.
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_last <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    // r_last resets to 0, so no spurious pulse leaves reset.
    assign o_fall  = r_last & ~r_sync[STAGES-1];

endmodule

// File: rtl/usrt_top.sv
// USRT transmitter: sends an incrementing test byte per frame on TXD,
// framed by RTS, paced by falling edges of the external bit clock.
module usrt_top
    import usrt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic   clk,
    input  logic   rst,
    usrt_if.slave  io_line
);

    logic                 w_tick;
    logic                 w_unused_uclk_level;
    logic                 w_start;
    logic [SYNC_STAGES-1:0] r_start_sync;

    state_e               r_state;
    logic [DATA_W-1:0]    r_cnt;
    logic [DATA_W-1:0]    r_shift;
    logic [BIT_IDX_W-1:0] r_idx;
    logic                 r_par_en;
    logic                 r_par;
    logic                 r_rts;
    logic                 r_txd;

    usrt_edge_sync #(.STAGES(SYNC_STAGES)) u_uclk_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (io_line.usrt_clk),
        .o_level (w_unused_uclk_level),
        .o_fall  (w_tick)
    );

    // Bring the start level into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_sync <= '0;
        end else begin
            r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], io_line.start};
        end
    end

    assign w_start = r_start_sync[SYNC_STAGES-1];

    // Frame sequencer: advances one bit time per tick; line outputs are
    // registered with the value of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_idx    <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_rts    <= 1'b0;
            r_txd    <= 1'b1;
        end else if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        // sw6 and the payload are frozen here for the whole frame.
                        r_par_en <= io_line.sw6;
                        r_shift  <= r_cnt;
                        r_par    <= ^r_cnt;
                        r_state  <= SETUP;
                        r_rts    <= 1'b1;
                        r_txd    <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state <= STRT;
                    r_txd   <= 1'b0;
                end
                STRT: begin
                    r_state <= DATA;
                    r_idx   <= '0;
                    r_txd   <= r_shift[0];
                    r_shift <= r_shift >> 1;
                end
                DATA: begin
                    if (r_idx == BIT_IDX_W'(DATA_W - 1)) begin
                        if (r_par_en) begin
                            r_state <= PAR;
                            r_txd   <= r_par;
                        end else begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                PAR: begin
                    r_state <= STOP;
                    r_txd   <= 1'b1;
                end
                STOP: begin
                    r_state <= IDLE;
                    r_rts   <= 1'b0;
                    r_txd   <= 1'b1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_rts   <= 1'b0;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign io_line.RTS = r_rts;
    assign io_line.TXD = r_txd;

endmodule

// File: tb/tb_usrt_top.sv
// Self-checking bench for usrt_top: captures the line once per bit time and
// compares each frame against a frame built from the byte/parity rules.
module tb_usrt_top;

    logic clk;
    logic rst;
    usrt_if u_line ();

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_cnt;
    int         pending_idle;

    usrt_top #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .io_line (u_line)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 20-unit bit clock, edges offset from clk so sampling is unambiguous
    initial begin
        u_line.usrt_clk = 1'b1;
        #3;
        forever begin
            u_line.usrt_clk = 1'b0;
            #10;
            u_line.usrt_clk = 1'b1;
            #10;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected TXD sequence of one frame, first bit at index 0; unused slots are 1.
    function automatic void model_frame(input logic [7:0] b, input bit par_en,
                                        output logic [15:0] bits, output int len);
        bits    = '1;
        bits[1] = 1'b0;
        for (int i = 0; i < 8; i++) bits[2 + i] = b[i];
        if (par_en) begin
            bits[10] = ^b;
            len      = 12;
        end else begin
            len = 11;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cnt        = 8'h00;
        pending_idle = 0;
    endtask

    // Sample the line once per bit; collect the next RTS-high run.
    task automatic grab_frame(input bit drop_start, input bit set_sw6, input bit sw6_val,
                              output logic [15:0] bits, output int len,
                              output int idle, output bit ok);
        bit in_frame;
        bits         = '1;
        len          = 0;
        idle         = pending_idle;
        ok           = 1'b0;
        in_frame     = 1'b0;
        pending_idle = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge u_line.usrt_clk);
            #1;
            if (!in_frame) begin
                if (u_line.RTS === 1'b1) begin
                    in_frame = 1'b1;
                    bits[0]  = u_line.TXD;
                    len      = 1;
                    if (drop_start) u_line.start = 1'b0;
                    if (set_sw6) u_line.sw6 = sw6_val;
                end else begin
                    idle++;
                end
            end else if (u_line.RTS === 1'b1) begin
                if (len < 16) bits[4'(len)] = u_line.TXD;
                len++;
            end else begin
                pending_idle = 1;
                ok           = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        u_line.start = 1'b0;
        u_line.sw6   = 1'b0;
        do_reset();
        n_cmp++;
        if (u_line.RTS !== 1'b0 || u_line.TXD !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_now: RTS=%b TXD=%b, expected RTS=0 TXD=1", u_line.RTS, u_line.TXD);
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge u_line.usrt_clk);
            #1;
            n_cmp++;
            if (u_line.RTS !== 1'b0 || u_line.TXD !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_idle bit %0d: RTS=%b TXD=%b, expected RTS=0 TXD=1",
                         k, u_line.RTS, u_line.TXD);
            end
        end
    endtask

    task automatic test_single_parity();
        logic [15:0] bits, eb;
        int len, el, idle, bad_idle;
        bit ok;
        u_line.sw6   = 1'b1;
        u_line.start = 1'b1;
        grab_frame(1'b1, 1'b0, 1'b0, bits, len, idle, ok);
        model_frame(m_cnt, 1'b1, eb, el);
        n_cmp++;
        if (ok !== 1'b1 || len !== el || bits !== eb) begin
            n_bad++;
            $display("FAIL single_frame: ok=%0d len=%0d txd=%h, expected len=%0d txd=%h",
                     ok, len, bits, el, eb);
        end
        m_cnt++;
        bad_idle = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge u_line.usrt_clk);
            #1;
            if (u_line.RTS !== 1'b0 || u_line.TXD !== 1'b1) bad_idle++;
        end
        n_cmp++;
        if (bad_idle !== 0) begin
            n_bad++;
            $display("FAIL single_after: %0d non-idle bits after start dropped, expected 0", bad_idle);
        end
    endtask

    task automatic test_continuous();
        logic [15:0] bits, eb;
        int len, el, idle;
        bit ok;
        do_reset();
        u_line.sw6   = 1'b1;
        u_line.start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            grab_frame(k == 5, 1'b0, 1'b0, bits, len, idle, ok);
            model_frame(m_cnt, 1'b1, eb, el);
            n_cmp++;
            if (ok !== 1'b1 || len !== el || bits !== eb) begin
                n_bad++;
                $display("FAIL cont_frame %0d: ok=%0d len=%0d txd=%h, expected len=%0d txd=%h",
                         k, ok, len, bits, el, eb);
            end
            if (k > 0) begin
                n_cmp++;
                if (idle !== 1) begin
                    n_bad++;
                    $display("FAIL cont_gap %0d: idle bits=%0d, expected 1", k, idle);
                end
            end
            m_cnt++;
        end
    endtask

    task automatic test_no_parity();
        logic [15:0] bits, eb;
        int len, el, idle;
        bit ok;
        // sw6 flips right after each frame starts; the frame keeps its latched setting.
        for (int k = 0; k < 2; k++) begin
            u_line.sw6   = 1'(k);
            u_line.start = 1'b1;
            grab_frame(1'b1, 1'b1, ~1'(k), bits, len, idle, ok);
            model_frame(m_cnt, 1'(k), eb, el);
            n_cmp++;
            if (ok !== 1'b1 || len !== el || bits !== eb) begin
                n_bad++;
                $display("FAIL sw6_toggle %0d: ok=%0d len=%0d txd=%h, expected len=%0d txd=%h",
                         k, ok, len, bits, el, eb);
            end
            m_cnt++;
        end
    endtask

    task automatic test_random();
        logic [15:0] bits, eb;
        int len, el, idle;
        bit ok, cur_par, nsw, drop, prev_drop;
        cur_par      = 1'($urandom_range(0, 1));
        u_line.sw6   = cur_par;
        u_line.start = 1'b1;
        prev_drop    = 1'b1;
        for (int k = 0; k < 24; k++) begin
            drop = ($urandom_range(0, 3) == 0);
            nsw  = 1'($urandom_range(0, 1));
            grab_frame(drop, 1'b1, nsw, bits, len, idle, ok);
            model_frame(m_cnt, cur_par, eb, el);
            n_cmp++;
            if (ok !== 1'b1 || len !== el || bits !== eb) begin
                n_bad++;
                $display("FAIL rand_frame %0d: ok=%0d len=%0d txd=%h, expected len=%0d txd=%h",
                         k, ok, len, bits, el, eb);
            end
            if (!prev_drop) begin
                n_cmp++;
                if (idle !== 1) begin
                    n_bad++;
                    $display("FAIL rand_gap %0d: idle bits=%0d, expected 1", k, idle);
                end
            end
            m_cnt++;
            cur_par   = nsw;
            prev_drop = drop;
            if (drop) begin
                repeat ($urandom_range(0, 4)) @(negedge u_line.usrt_clk);
                u_line.start = 1'b1;
            end
        end
        u_line.start = 1'b0;
    endtask

    task automatic test_abort();
        logic [15:0] bits, eb;
        int len, el, idle;
        bit ok, found_lo, found_hi;
        u_line.sw6   = 1'b1;
        u_line.start = 1'b1;
        found_lo = 1'b0;
        found_hi = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge u_line.usrt_clk);
            #1;
            if (u_line.RTS === 1'b0) begin
                found_lo = 1'b1;
                break;
            end
        end
        for (int n = 0; n < 60; n++) begin
            @(negedge u_line.usrt_clk);
            #1;
            if (u_line.RTS === 1'b1) begin
                found_hi = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!(found_lo && found_hi)) begin
            n_bad++;
            $display("FAIL abort_wait: frame start seen=%0d, expected 1", found_lo && found_hi);
        end
        // SETUP was just seen; four more bits puts the line inside the data bits.
        repeat (4) begin
            @(negedge u_line.usrt_clk);
            #1;
        end
        n_cmp++;
        if (u_line.RTS !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_mid: RTS=%b before reset, expected 1", u_line.RTS);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (u_line.RTS !== 1'b0 || u_line.TXD !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_reset: RTS=%b TXD=%b, expected RTS=0 TXD=1", u_line.RTS, u_line.TXD);
        end
        rst          = 1'b0;
        m_cnt        = 8'h00;
        pending_idle = 0;
        grab_frame(1'b1, 1'b0, 1'b0, bits, len, idle, ok);
        model_frame(m_cnt, 1'b1, eb, el);
        n_cmp++;
        if (ok !== 1'b1 || len !== el || bits !== eb) begin
            n_bad++;
            $display("FAIL abort_next: ok=%0d len=%0d txd=%h, expected len=%0d txd=%h",
                     ok, len, bits, el, eb);
        end
        m_cnt++;
    endtask

    task automatic test_wrap();
        logic [15:0] bits, eb;
        int len, el, idle;
        bit ok;
        do_reset();
        u_line.sw6   = 1'b1;
        u_line.start = 1'b1;
        for (int k = 0; k < 257; k++) begin
            grab_frame(k == 256, 1'b0, 1'b0, bits, len, idle, ok);
            model_frame(m_cnt, 1'b1, eb, el);
            n_cmp++;
            if (ok !== 1'b1 || len !== el || bits !== eb) begin
                n_bad++;
                $display("FAIL wrap_frame %0d: ok=%0d len=%0d txd=%h, expected len=%0d txd=%h",
                         k, ok, len, bits, el, eb);
            end
            if (k > 0) begin
                n_cmp++;
                if (idle !== 1) begin
                    n_bad++;
                    $display("FAIL wrap_gap %0d: idle bits=%0d, expected 1", k, idle);
                end
            end
            m_cnt++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        u_line.start = 1'b0;
        u_line.sw6   = 1'b0;
        m_cnt        = 8'h00;
        pending_idle = 0;
        test_reset();
        test_single_parity();
        test_continuous();
        test_no_parity();
        test_random();
        test_abort();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usrt_top.md
Name: usrt_top

Overview:
- Self-contained USRT transmitter top level: emits a stream of test bytes on TXD with an RTS framing qualifier.
- Bit timing comes from an external bit-clock input, usrt_clk, which is treated as a data input and sampled in the clk domain.
- Transmission is enabled by the start level. sw6 selects whether an even-parity bit is sent.
- Byte payload comes from an internal 8-bit counter, so the block needs no data input. Used as the board-level top driving a serial line.

Parameters:
- DATA_W, 8, payload bits per frame.
- SYNC_STAGES, 2, synchroniser depth for usrt_clk and start.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- usrt_clk  input  1  external bit clock, sampled by clk; each level stable for ≥1 clk period.
- start  input  1  transmit enable (level); frames repeat while high.
- sw6  input  1  parity enable: 1 = even parity bit appended, 0 = no parity bit.
- RTS  output  1  high while a frame is on the line.
- TXD  output  1  serial data, idles high.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset values: RTS=0, TXD=1, state=IDLE, byte counter=0x00, synchroniser flops=0. Reset mid-frame aborts immediately, with no partial stop bit.
- usrt_clk and start each pass through SYNC_STAGES flops.
- A bit tick is a one-clk pulse when the synchronised usrt_clk was 1 last cycle and is 0 now, i.e. a falling edge.
- All state/RTS/TXD updates occur only on the clk edge after a tick. Latency is 3 clk cycles from the usrt_clk falling edge to the TXD/RTS change, so receivers sample on the usrt_clk rising edge.
- States, one bit time each except DATA:
  - IDLE: RTS=0, TXD=1. On tick with synced start=1: latch sw6 into par_en, load shift reg from counter, go to SETUP.
  - SETUP: RTS=1, TXD=1. Next tick goes to STRT.
  - STRT: TXD=0. Next tick goes to DATA with bit index 0.
  - DATA: TXD=shift[0], LSB first, 8 ticks. After bit 7: go to PAR if par_en, else STOP.
  - PAR: TXD = XOR of the 8 data bits (even parity).
  - STOP: TXD=1, RTS=1. Next tick goes to IDLE and increments the counter (mod 256, 0xFF wraps to 0x00).
- Frame length: 12 bit times with parity, 11 without. At least one IDLE bit time separates frames, with RTS low during it.
- start dropping mid-frame: the current frame completes normally and no new frame begins.
- start high at the end of IDLE's first tick: the next frame starts on that tick, so back-to-back frames are separated by exactly one IDLE bit.
- sw6 changes mid-frame are ignored until the next SETUP.
- No tick while rst=1. The first tick after reset release is evaluated normally.
- TXD and RTS are registered outputs, glitch-free.

Decomposition:
- Package usrt_pkg:
  - state enum {IDLE, SETUP, STRT, DATA, PAR, STOP}
  - DATA_W constant
  - bit-index width constant
- Natural sub-module: usrt_edge_sync. It synchronises one async input and produces the synced level plus a falling-edge pulse, and is instantiated for usrt_clk (start uses only the synced level).
- Remaining logic is a single FSM + shift register + byte counter in usrt_top.

Test Plan:
- Reset: clk 10 ns, usrt_clk 20 ns period, rst pulsed 1 cycle with start=0 → RTS=0, TXD=1 held for 50 bit times.
- Single frame with parity: sw6=1, start=1 for one frame then 0 → RTS high for 12 bits; TXD sequence 1,0,00000000,0,1 (byte 0x00, parity 0); then RTS=0, TXD=1.
- Continuous run: sw6=1, start held 10 µs → frames carry 0x00, 0x01, 0x02… LSB first. Frame 0x01 has data 1,0,0,0,0,0,0,0 and parity 1. Exactly one idle bit (RTS=0) between frames.
- No parity: sw6=0 → 11-bit frames, with STOP immediately after data bit 7. Toggling sw6 mid-frame does not alter that frame.
- Abort: assert rst during DATA → next clk RTS=0, TXD=1, counter=0x00. The following frame transmits 0x00.
- Wrap: preload by running 255 frames → byte 0xFF (parity 0) is followed by 0x00.
